// File: rtl/line_pixel_stepper.sv
// Bresenham minor-axis stepper: turns a stream of major-axis x beats into registered pixels.
// Optional screen clipping is compiled in with `define LINE_PIXEL_STEPPER_CLIP_EN.
module line_pixel_stepper #(
  parameter int unsigned WIDTH    = 13,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dx_i,
  input  logic [WIDTH-1:0] dy_i,
  input  logic [WIDTH-1:0] y0_i,
  input  logic             ystep_neg_i,
  input  logic             steep_i,
  input  logic [WIDTH-1:0] x_in_i,
  input  logic             x_valid_i,
  input  logic             x_last_i,
  output logic             x_ready_o,
  output logic [WIDTH-1:0] pix_x_o,
  output logic [WIDTH-1:0] pix_y_o,
  output logic             pix_valid_o,
  input  logic             pix_ready_i,
  output logic             done_o
);

  // Screen extents must be representable as positive signed coordinates.
  if (SCREEN_W >= (1 << (WIDTH - 1)) || SCREEN_H >= (1 << (WIDTH - 1))) begin : g_bad_screen
    $error("SCREEN_W/SCREEN_H do not fit the signed coordinate width");
  end

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        dx_q, dx_d;
  logic [WIDTH-1:0]        dy_q, dy_d;
  logic [WIDTH-1:0]        y_q, y_d;
  logic signed [WIDTH:0]   err_q, err_d;
  logic                    ystep_neg_q, ystep_neg_d;
  logic                    steep_q, steep_d;
  logic [WIDTH-1:0]        pix_x_q, pix_x_d;
  logic [WIDTH-1:0]        pix_y_q, pix_y_d;
  logic                    pix_valid_q, pix_valid_d;

  logic                    x_ready;
  logic                    accept;
  logic                    emit;
  logic signed [WIDTH:0]   err_e;
  logic [WIDTH-1:0]        cand_x, cand_y;

`ifdef LINE_PIXEL_STEPPER_CLIP_EN
  localparam logic signed [WIDTH:0] ScreenW = (WIDTH + 1)'(SCREEN_W);
  localparam logic signed [WIDTH:0] ScreenH = (WIDTH + 1)'(SCREEN_H);

  logic signed [WIDTH:0] sx, sy;

  always_comb begin
    sx   = {cand_x[WIDTH-1], cand_x};
    sy   = {cand_y[WIDTH-1], cand_y};
    emit = !sx[WIDTH] && (sx < ScreenW) && !sy[WIDTH] && (sy < ScreenH);
  end
`else
  assign emit = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    y_d         = y_q;
    err_d       = err_q;
    ystep_neg_d = ystep_neg_q;
    steep_d     = steep_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_valid_d = pix_valid_q;

    x_ready = (state_q == StRun) && (!pix_valid_q || pix_ready_i);
    accept  = x_ready && x_valid_i;
    err_e   = err_q - $signed({1'b0, dy_q});
    cand_x  = steep_q ? y_q : x_in_i;
    cand_y  = steep_q ? x_in_i : y_q;

    if (pix_valid_q && pix_ready_i) begin
      pix_valid_d = 1'b0;
    end

    if (accept) begin
      pix_x_d     = cand_x;
      pix_y_d     = cand_y;
      pix_valid_d = emit;
      if (err_e[WIDTH]) begin
        y_d   = ystep_neg_q ? y_q - 1'b1 : y_q + 1'b1;
        err_d = err_e + $signed({1'b0, dx_q});
      end else begin
        err_d = err_e;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          dx_d        = dx_i;
          dy_d        = dy_i;
          ystep_neg_d = ystep_neg_i;
          steep_d     = steep_i;
          y_d         = y0_i;
          err_d       = $signed({2'b00, dx_i[WIDTH-1:1]});
        end
      end
      StRun: begin
        if (accept && x_last_i) state_d = StFlush;
      end
      StFlush: begin
        if (!pix_valid_q || pix_ready_i) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      dx_q        <= '0;
      dy_q        <= '0;
      y_q         <= '0;
      err_q       <= '0;
      ystep_neg_q <= 1'b0;
      steep_q     <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      y_q         <= y_d;
      err_q       <= err_d;
      ystep_neg_q <= ystep_neg_d;
      steep_q     <= steep_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign x_ready_o   = x_ready;
  assign pix_x_o     = pix_x_q;
  assign pix_y_o     = pix_y_q;
  assign pix_valid_o = pix_valid_q;
  assign done_o      = (state_q == StDone);

endmodule
